// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between a CPU data-memory port
// and the pipelined memory responder.
//   enable, wr, addr, data_in      : request side, driven by the master
//   data_out, data_valid, data_addr: read return, driven by the responder
//   busy, outstanding              : in-flight read status, driven by the responder
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  enable;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           data_in;
  logic [15:0]           data_out;
  logic                  data_valid;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  busy;
  logic [3:0]            outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, data_addr, busy, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, data_addr, busy, outstanding
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fully pipelined 16-bit data memory. One request per cycle;
// reads return LATENCY edges after acceptance with a valid strobe and an
// address echo, in acceptance order.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (pipeline and counters only; the
//          array keeps its contents)
//   bus  : mem_responder_if.slave
//          enable/wr/addr/data_in    request (addr bit 0 ignored)
//          data_out/data_valid/data_addr  read return, all zero when idle
//          outstanding               reads accepted and not yet retired
//          busy                      outstanding != 0
module mem_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INDEX_WIDTH = 10,
  parameter int LATENCY     = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  // Clears bit 0 of the echoed address while keeping every other bit.
  localparam logic [ADDR_WIDTH-1:0] EVEN_MASK = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  logic [15:0]           mem_q [DEPTH];

  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [15:0]           dat_q [LATENCY];
  logic [15:0]           dat_d [LATENCY];
  logic [ADDR_WIDTH-1:0] adr_q [LATENCY];
  logic [ADDR_WIDTH-1:0] adr_d [LATENCY];
  logic [3:0]            cnt_q, cnt_d;

  logic                   rd_acc_s;
  logic                   wr_acc_s;
  logic                   retire_s;
  logic [INDEX_WIDTH-1:0] idx_s;

  // Request decode, next-state for the read pipeline and the in-flight counter.
  always_comb begin
    rd_acc_s = bus.enable && !bus.wr;
    wr_acc_s = bus.enable && bus.wr;
    idx_s    = bus.addr[INDEX_WIDTH:1];
    // The last stage is presenting data this cycle; it leaves at the next edge.
    retire_s = vld_q[LATENCY-1];

    // Stage 0 samples the array before this edge's write could land, so a
    // read always sees writes from earlier edges only. Idle stages carry
    // zeros so the outputs never show stale data.
    vld_d[0] = rd_acc_s;
    if (rd_acc_s) begin
      dat_d[0] = mem_q[idx_s];
      adr_d[0] = bus.addr & EVEN_MASK;
    end else begin
      dat_d[0] = 16'h0000;
      adr_d[0] = {ADDR_WIDTH{1'b0}};
    end

    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
      adr_d[i] = adr_q[i-1];
    end

    // Accept and retire in the same cycle cancel out; the pipeline depth
    // bounds the count at LATENCY.
    cnt_d = cnt_q + {3'b000, rd_acc_s} - {3'b000, retire_s};
  end

  // Pipeline, counter and array update. The array sits under the reset
  // branch only so that requests seen during reset are dropped; it is
  // never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= {LATENCY{1'b0}};
      cnt_q <= 4'd0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= 16'h0000;
        adr_q[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
        adr_q[i] <= adr_d[i];
      end
      if (wr_acc_s) begin
        mem_q[idx_s] <= bus.data_in;
      end
    end
  end

  assign bus.data_valid  = vld_q[LATENCY-1];
  assign bus.data_out    = dat_q[LATENCY-1];
  assign bus.data_addr   = adr_q[LATENCY-1];
  assign bus.outstanding = cnt_q;
  assign bus.busy        = (cnt_q != 4'd0);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives identical request streams into a LATENCY=4 and a
// LATENCY=1 responder. A reference memory array produces the expected read
// value at acceptance time; expected returns (data, address, sample time)
// queue per instance and a negedge monitor compares every cycle.
module tb_mem_responder;

  localparam int AW    = 16;
  localparam int IW    = 10;
  localparam int DEPTH = 1 << IW;

  typedef struct {
    logic [15:0] data;
    logic [15:0] addr;
    time         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req_en   = 1'b0;
  logic        req_wr   = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_data = 16'h0000;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [DEPTH];
  exp_t        exp_q [2][$];

  mem_responder_if #(.ADDR_WIDTH(AW)) bus4 ();
  mem_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

  assign bus4.enable  = req_en;
  assign bus4.wr      = req_wr;
  assign bus4.addr    = req_addr;
  assign bus4.data_in = req_data;
  assign bus1.enable  = req_en;
  assign bus1.wr      = req_wr;
  assign bus1.addr    = req_addr;
  assign bus1.data_in = req_data;

  mem_responder #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));
  mem_responder #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (LATENCY=%0d) t=%0t: got %0h expected %0h",
               name, lat(k), $time, act, exp);
    end
  endtask

  // Reference model: apply accepted requests at the clock edge.
  always @(posedge clk) begin
    if (!rst && req_en) begin
      int idx;
      idx = int'(req_addr >> 1) % DEPTH;
      if (req_wr) begin
        ref_mem[idx] = req_data;
      end else begin
        for (int k = 0; k < 2; k++) begin
          exp_q[k].push_back('{data: ref_mem[idx], addr: req_addr & 16'hFFFE,
                               due: $time + time'((lat(k) - 1) * 10 + 5)});
        end
      end
    end
  end

  // Reset drops everything in flight.
  always @(posedge rst) begin
    exp_q[0].delete();
    exp_q[1].delete();
  end

  task automatic mon(input int k, input logic dv, input logic [15:0] dout,
                     input logic [15:0] dadr, input logic [3:0] outs,
                     input logic bsy);
    exp_t e;
    chk("outstanding", k, 32'(outs), 32'(exp_q[k].size()));
    chk("busy", k, 32'(bsy), 32'(exp_q[k].size() != 0));
    if (exp_q[k].size() != 0 && exp_q[k][0].due == $time) begin
      e = exp_q[k].pop_front();
      chk("data_valid", k, 32'(dv), 32'd1);
      chk("data_out", k, 32'(dout), 32'(e.data));
      chk("data_addr", k, 32'(dadr), 32'(e.addr));
    end else begin
      chk("data_valid_idle", k, 32'(dv), 32'd0);
      chk("data_out_idle", k, 32'(dout), 32'd0);
      chk("data_addr_idle", k, 32'(dadr), 32'd0);
    end
  endtask

  // Monitor: compare both instances every cycle, away from the active edge.
  always @(negedge clk) begin
    mon(0, bus4.data_valid, bus4.data_out, bus4.data_addr, bus4.outstanding, bus4.busy);
    mon(1, bus1.data_valid, bus1.data_out, bus1.data_addr, bus1.outstanding, bus1.busy);
  end

  // Present one request for the next edge, return 1 time unit after it.
  task automatic req(input logic en, input logic wr, input logic [15:0] a,
                     input logic [15:0] d);
    req_en   = en;
    req_wr   = wr;
    req_addr = a;
    req_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wr_w(input logic [15:0] a, input logic [15:0] d);
    req(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_w(input logic [15:0] a);
    req(1'b1, 1'b0, a, 16'h0000);
  endtask

  task automatic reset_checks();
    chk("rst_outstanding", 0, 32'(bus4.outstanding), 32'(exp_q[0].size()));
    chk("rst_busy", 0, 32'(bus4.busy), 32'd0);
    chk("rst_data_valid", 0, 32'(bus4.data_valid), 32'd0);
    chk("rst_outstanding", 1, 32'(bus1.outstanding), 32'(exp_q[1].size()));
    chk("rst_busy", 1, 32'(bus1.busy), 32'd0);
    chk("rst_data_valid", 1, 32'(bus1.data_valid), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    reset_checks();
    chk("rst_data_out", 0, 32'(bus4.data_out), 32'd0);
    chk("rst_data_addr", 0, 32'(bus4.data_addr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Give every word a known value so random reads can be predicted.
    for (int i = 0; i < DEPTH; i++) wr_w(16'(i * 2), 16'($urandom));
    idle(2);

    // Write then read at the next edge.
    wr_w(16'h0010, 16'hBEEF);
    rd_w(16'h0010);
    idle(6);

    // Back-to-back reads.
    wr_w(16'h0000, 16'h1111);
    wr_w(16'h0002, 16'h2222);
    wr_w(16'h0004, 16'h3333);
    rd_w(16'h0000);
    rd_w(16'h0002);
    rd_w(16'h0004);
    idle(6);

    // Hazard ordering on one address.
    wr_w(16'h0020, 16'h00AA);
    rd_w(16'h0020);
    wr_w(16'h0020, 16'h5555);
    wr_w(16'h0020, 16'h6666);
    rd_w(16'h0020);
    idle(6);

    // Bit 0 ignored, high bits wrap.
    wr_w(16'h0031, 16'h7777);
    rd_w(16'h0030);
    wr_w(16'h0800, 16'h8888);
    rd_w(16'h0000);
    rd_w(16'hF802);
    idle(6);

    // Reset mid-flight: two reads in flight, async pulse between edges.
    wr_w(16'h0040, 16'hCAFE);
    rd_w(16'h0040);
    rd_w(16'h0042);
    req_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    reset_checks();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    // A request presented while reset is held across an edge is ignored.
    req_en = 1'b1; req_wr = 1'b1; req_addr = 16'h0040; req_data = 16'hDEAD;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    rd_w(16'h0040);
    idle(6);

    // Alternating write/read over 16 addresses.
    for (int i = 0; i < 16; i++) begin
      wr_w(16'(16'h0100 + i * 2), 16'(16'hA000 + i * 16'h0101));
      rd_w(16'(16'h0100 + i * 2));
    end
    idle(6);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          16'($urandom), 16'($urandom));
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle, fully pipelined data-memory responder.
- Serves the request side of the CPU's data-memory interface: enable, wr, addr, data_in.
- Accepts one request per cycle and returns read data a fixed LATENCY cycles later, with a valid strobe and an address echo.
- Replaces the single-cycle data memory ahead of the cache/stall work.

Parameters:
- ADDR_WIDTH, 16: width of the byte address on addr.
- INDEX_WIDTH, 10: word-index bits used. Depth is 2^INDEX_WIDTH 16-bit words.
- LATENCY, 4: cycles from request acceptance to data_valid. Legal range is 1..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- enable  input  1  request strobe; a request is accepted on any rising edge where enable=1
- wr  input  1  1 = write, 0 = read; sampled only when enable=1
- addr  input  ADDR_WIDTH  byte address; bit 0 is ignored
- data_in  input  16  write data
- data_out  output  16  read data, meaningful only when data_valid=1
- data_valid  output  1  one-cycle strobe per completed read
- data_addr  output  ADDR_WIDTH  echo of the accepted read address, bit 0 forced to 0
- busy  output  1  1 while any read is in flight, or while data_valid=1
- outstanding  output  4  count of reads accepted but not yet returned

Behaviour:
- Reset (async, rst=1): data_valid=0, data_out=0, data_addr=0, busy=0, outstanding=0, all pipeline valid bits cleared.
  - Memory array contents are not reset; they hold their values across reset.
- Indexing: word index = addr[INDEX_WIDTH:1]. Higher address bits are ignored, so addresses wrap modulo 2^(INDEX_WIDTH+1) bytes.
- Write (enable=1, wr=1): the array updates at the accepting edge. A write produces no data_valid and no outstanding increment.
- Read (enable=1, wr=0): the array is sampled at the accepting edge.
  - The returned value reflects every write accepted on earlier edges.
  - The read enters a LATENCY-deep shift pipeline carrying valid, data and address.
- Timing: a read accepted at edge N gives data_valid=1 with data_out and data_addr after edge N+LATENCY-1, i.e. during cycle N+LATENCY-1 to N+LATENCY. Net latency is exactly LATENCY edges counted from the accepting edge to the edge at which the consumer samples.
  - LATENCY=1 behaves as a registered single-cycle memory.
- Back-to-back reads: one read per cycle is accepted. Results return in order, one per cycle, and there are no bubbles unless requests have gaps.
- Read then write to the same address on consecutive cycles: the read returns the old value.
  - The ordering is fixed by acceptance order, not by return time.
- Write then read to the same address on consecutive cycles: the read returns the new value.
- Outputs when data_valid=0: data_out and data_addr hold 0. They do not hold stale data.
- outstanding counter:
  - +1 on an accepted read.
  - -1 when a read leaves the pipeline, i.e. on the edge after data_valid was high.
  - A simultaneous accept and retire leaves the count unchanged.
  - The count never exceeds LATENCY, so it cannot overflow 4 bits.
- busy = (outstanding != 0). This is combinational from the registered count.
- Reset asserted mid-operation: all in-flight reads are dropped immediately, with no late data_valid after rst deasserts.
  - Writes already accepted remain in the array.
  - A request presented while rst=1 is ignored.
- enable=0: no state change except pipeline advance.

Test Plan:
1. Reset, then write 0xBEEF to addr 0x0010 and read 0x0010 at the next edge (LATENCY=4) -> data_valid high exactly 4 edges after the read is accepted, data_out=0xBEEF, data_addr=0x0010, outstanding 1..1 then 0.
2. Back-to-back reads:
   - Stimulus: write 0x1111, 0x2222, 0x3333 to 0x0000, 0x0002, 0x0004; then three consecutive reads.
   - Response: three consecutive data_valid cycles returning 0x1111, 0x2222, 0x3333 in order; outstanding peaks at 3.
3. Hazard ordering on addr 0x0020 (initially 0x00AA):
   - Read then write 0x5555 on consecutive cycles -> the read returns 0x00AA.
   - Write 0x6666 then read -> the read returns 0x6666.
4. Address handling:
   - Write 0x7777 to 0x0031, read 0x0030 -> 0x7777 (bit 0 ignored).
   - With INDEX_WIDTH=10, write to 0x0800 and read 0x0000 -> same word (wrap).
5. Reset mid-flight: issue reads at two consecutive edges, then pulse rst asynchronously between edges -> data_valid never asserts, outstanding=0 and busy=0 immediately; a prior write of 0xCAFE is still read back as 0xCAFE after reset.
6. LATENCY=1 build: alternate write/read every cycle for 16 addresses -> each read's data_valid appears at the next edge with the matching value; outstanding toggles 0/1.
